// File: rtl/ao311_share_arb_if.sv
// Requester-side bundle for the shared ao311 arbiter:
// requests and operands in, one-hot grant and tagged result out.
interface ao311_share_arb_if #(
  parameter int N  = 4,
  parameter int IW = 2
);
  logic [N-1:0]   req;
  logic [5*N-1:0] opnd;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic           rsp_z;

  modport master (
    output req, opnd,
    input  gnt, rsp_valid, rsp_id, rsp_z
  );

  modport slave (
    input  req, opnd,
    output gnt, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/ao311_share_arb.sv
// Round-robin sharing of one ao311 cell among N requesters:
// grant, latch operands, evaluate next cycle, return tagged result.
module ao311 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic z
);
  assign z = (a & b & c) | (d | e);
endmodule

module ao311_share_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input logic clk,
  input logic rst_n,
  ao311_share_arb_if.slave bus
);

  typedef enum logic {
    IDLE,
    EVAL
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [4:0]    op_q;
  logic [IW-1:0] id_q;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [IW-1:0] ptr_nxt;
  logic [4:0]    win_op;
  logic          z;

  // Scan from ptr upward; explicit wrap keeps non-power-of-2 N legal.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  assign ptr_nxt = (win == LAST) ? '0 : win + 1'b1;
  assign win_op  = bus.opnd[5*int'(win) +: 5];

  ao311 u_cell (
    .a (op_q[4]),
    .b (op_q[3]),
    .c (op_q[2]),
    .d (op_q[1]),
    .e (op_q[0]),
    .z (z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      op_q          <= '0;
      id_q          <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_z     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          if (found) begin
            state   <= EVAL;
            op_q    <= win_op;
            id_q    <= win;
            ptr     <= ptr_nxt;
            bus.gnt <= {{(N-1){1'b0}}, 1'b1} << win;
          end else begin
            bus.gnt <= '0;
          end
        end
        EVAL: begin
          state         <= IDLE;
          bus.gnt       <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_z     <= z;
          bus.rsp_id    <= id_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
